// File: rtl/sequential_divider_signed.sv
// Iterative signed divider: restoring division on operand magnitudes, one quotient
// bit per clock, then a one-cycle sign fix-up. The quotient truncates toward zero.
module sequential_divider_signed #(
  parameter int DATA_WIDTH_A = 8,
  parameter int DATA_WIDTH_B = 8
) (
  input  logic                           i_clk,
  input  logic                           i_nrst,
  input  logic signed [DATA_WIDTH_A-1:0] i_a,
  input  logic signed [DATA_WIDTH_B-1:0] i_b,
  input  logic                           i_valid,
  output logic                           o_accept,
  output logic signed [DATA_WIDTH_A-1:0] o_q,
  output logic signed [DATA_WIDTH_B-1:0] o_r,
  output logic                           o_valid,
  output logic                           o_dbz
);
  localparam int CNT_W = $clog2(DATA_WIDTH_A);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH_A - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;

  // dvd starts as |a|; quotient bits shift in at the bottom as dividend bits leave the top
  logic [DATA_WIDTH_A-1:0] dvd;
  logic [DATA_WIDTH_B-1:0] dvs;
  logic [DATA_WIDTH_B:0]   rem;
  logic [CNT_W-1:0]        cnt;
  logic                    sign_q;
  logic                    sign_r;
  logic                    dbz;
  logic [DATA_WIDTH_B:0]   rem_sh;
  logic [DATA_WIDTH_B+1:0] trial;

  function automatic logic [DATA_WIDTH_A-1:0] neg_a(input logic [DATA_WIDTH_A-1:0] v,
                                                    input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [DATA_WIDTH_B-1:0] neg_b(input logic [DATA_WIDTH_B-1:0] v,
                                                    input logic neg);
    return neg ? -v : v;
  endfunction

  assign o_accept = (state == IDLE);
  assign rem_sh   = {rem[DATA_WIDTH_B-1:0], dvd[DATA_WIDTH_A-1]};
  assign trial    = {1'b0, rem_sh} - {2'b00, dvs};

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_valid) state_nx = CALC;
      CALC:    if (cnt == '0) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      cnt     <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      dbz     <= 1'b0;
      o_q     <= '0;
      o_r     <= '0;
      o_dbz   <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: if (i_valid) begin
          dvd    <= neg_a(i_a, i_a[DATA_WIDTH_A-1]);
          dvs    <= neg_b(i_b, i_b[DATA_WIDTH_B-1]);
          sign_q <= i_a[DATA_WIDTH_A-1] ^ i_b[DATA_WIDTH_B-1];
          sign_r <= i_a[DATA_WIDTH_A-1];
          dbz    <= (i_b == '0);
          rem    <= '0;
          cnt    <= CNT_LOAD;
        end
        CALC: begin
          // negative trial difference means |b| did not fit: restore and shift in 0
          if (!trial[DATA_WIDTH_B+1]) begin
            rem <= trial[DATA_WIDTH_B:0];
            dvd <= {dvd[DATA_WIDTH_A-2:0], 1'b1};
          end else begin
            rem <= rem_sh;
            dvd <= {dvd[DATA_WIDTH_A-2:0], 1'b0};
          end
          cnt <= cnt - CNT_W'(1);
        end
        FIX: begin
          o_q     <= dbz ? '1 : neg_a(dvd, sign_q);
          o_r     <= dbz ? '0 : neg_b(rem[DATA_WIDTH_B-1:0], sign_r);
          o_dbz   <= dbz;
          o_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sequential_divider_signed.sv
// Scoreboard bench for sequential_divider_signed: an 8/8 instance for directed cases
// and a 16/4 instance for a random sweep with arithmetic-identity checks.
module tb_sequential_divider_signed;
  typedef struct {
    int a;
    int b;
    int q;
    int r;
    bit dbz;
    int t;
  } exp_t;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges++;

  int checks = 0;
  int errors = 0;

  // 8/8 instance
  logic signed [7:0] a8 = '0, b8 = '0;
  logic v8 = 1'b0;
  logic acc8, vld8, dbz8;
  logic signed [7:0] q8, r8;

  // 16/4 instance
  logic signed [15:0] a16 = '0;
  logic signed [3:0] b16 = '0;
  logic v16 = 1'b0;
  logic acc16, vld16, dbz16;
  logic signed [15:0] q16;
  logic signed [3:0] r16;

  sequential_divider_signed #(.DATA_WIDTH_A(8), .DATA_WIDTH_B(8)) u_div8 (
    .i_clk(clk), .i_nrst(nrst), .i_a(a8), .i_b(b8), .i_valid(v8),
    .o_accept(acc8), .o_q(q8), .o_r(r8), .o_valid(vld8), .o_dbz(dbz8)
  );

  sequential_divider_signed #(.DATA_WIDTH_A(16), .DATA_WIDTH_B(4)) u_div16 (
    .i_clk(clk), .i_nrst(nrst), .i_a(a16), .i_b(b16), .i_valid(v16),
    .o_accept(acc16), .o_q(q16), .o_r(r16), .o_valid(vld16), .o_dbz(dbz16)
  );

  exp_t sb8[$];
  exp_t sb16[$];
  exp_t e8, e16;
  int last8 = 0;
  int last16 = 0;
  int lastq8 = 0;
  int lastr8 = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int sext(input int v, input int w);
    return (v <<< (32 - w)) >>> (32 - w);
  endfunction

  function automatic exp_t model(input int a, input int b, input int wa, input int wb,
                                 input int t);
    exp_t e;
    e.a = a;
    e.b = b;
    e.t = t;
    if (b == 0) begin
      e.q = -1;
      e.r = 0;
      e.dbz = 1'b1;
    end else begin
      e.q = sext(a / b, wa);
      e.r = sext(a % b, wb);
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Transfers one operand pair; while waiting for o_accept the operands are scrambled
  // with i_valid high, which the divider must ignore.
  task automatic send8(input int a, input int b, input bit push, input bit hold);
    int n = 0;
    int t;
    exp_t e;
    @(negedge clk);
    while (!acc8 && n < 100) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      v8 = hold;
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept8_timeout", n, 0);
    a8 = 8'(a);
    b8 = 8'(b);
    v8 = 1'b1;
    t = edges + 1;
    if (hold && last8 != 0) check("gap8", t - last8, 10);
    last8 = t;
    if (push) begin
      e = model(a, b, 8, 8, t);
      sb8.push_back(e);
      lastq8 = e.q;
      lastr8 = e.r;
    end
    @(posedge clk);
    #1;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    if (!hold) v8 = 1'b0;
  endtask

  task automatic send16(input int a, input int b, input bit hold);
    int n = 0;
    int t;
    @(negedge clk);
    while (!acc16 && n < 100) begin
      a16 = 16'($urandom);
      b16 = 4'($urandom);
      v16 = hold;
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept16_timeout", n, 0);
    a16 = 16'(a);
    b16 = 4'(b);
    v16 = 1'b1;
    t = edges + 1;
    if (hold && last16 != 0) check("gap16", t - last16, 18);
    last16 = t;
    sb16.push_back(model(a, b, 16, 4, t));
    @(posedge clk);
    #1;
    if (!hold) v16 = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while ((sb8.size() > 0 || sb16.size() > 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", sb8.size() + sb16.size(), 0);
  endtask

  always @(negedge clk) begin
    if (vld8) begin
      if (sb8.size() == 0) check("stray_valid8", 1, 0);
      else begin
        e8 = sb8.pop_front();
        check("q8", q8, e8.q);
        check("r8", r8, e8.r);
        check("dbz8", dbz8, e8.dbz);
        check("lat8", edges + 1 - e8.t, 10);
      end
    end
  end

  int qi, ri, ai, bi;
  bit ok;
  always @(negedge clk) begin
    if (vld16) begin
      if (sb16.size() == 0) check("stray_valid16", 1, 0);
      else begin
        e16 = sb16.pop_front();
        check("q16", q16, e16.q);
        check("r16", r16, e16.r);
        check("dbz16", dbz16, e16.dbz);
        check("lat16", edges + 1 - e16.t, 18);
        if (!e16.dbz) begin
          qi = q16;
          ri = r16;
          ai = e16.a;
          bi = e16.b;
          ok = (((qi * bi + ri) & 32'hFFFF) == (ai & 32'hFFFF)) &&
               (ri == 0 || ((ri < 0) == (ai < 0))) &&
               ((ri < 0 ? -ri : ri) < (bi < 0 ? -bi : bi));
          check("identity16", ok, 1);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [3:0] rb;
    #3 nrst = 1'b0;
    #2;
    check("rst_accept", acc8, 1);
    check("rst_valid", vld8, 0);
    check("rst_q", q8, 0);
    check("rst_r", r8, 0);
    check("rst_dbz", dbz8, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    send8(100, 7, 1, 0);
    send8(-100, 7, 1, 0);
    send8(100, -7, 1, 0);
    send8(-100, -7, 1, 0);
    send8(-128, -1, 1, 0);
    send8(-128, 1, 1, 0);
    send8(127, -128, 1, 0);
    send8(-128, -128, 1, 0);
    send8(5, 0, 1, 0);
    send8(6, 3, 1, 0);
    send8(-77, 10, 1, 0);
    drain();
    repeat (3) @(negedge clk);
    check("hold_q8", q8, lastq8);
    check("hold_r8", r8, lastr8);

    last8 = 0;
    for (int i = 0; i < 8; i++) send8($signed(8'($urandom)), $signed(8'($urandom)), 1, 1);
    send8(50, 3, 1, 0);
    drain();

    send8(100, 7, 0, 0);
    repeat (4) @(negedge clk);
    nrst = 1'b0;
    #1;
    check("midrst_accept", acc8, 1);
    check("midrst_valid", vld8, 0);
    check("midrst_q", q8, 0);
    check("midrst_r", r8, 0);
    check("midrst_dbz", dbz8, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (15) @(negedge clk);
    check("post_rst_accept", acc8, 1);
    send8(9, 2, 1, 0);
    drain();

    send16(-32768, -1, 0);
    send16(-32768, 1, 0);
    send16(32767, -8, 0);
    send16(-32768, -8, 0);
    send16(123, 0, 0);
    send16(-1, 7, 0);
    drain();
    last16 = 0;
    for (int i = 0; i < 2500; i++) begin
      rb = 4'($urandom);
      send16($signed(16'($urandom)), rb, 1);
    end
    v16 = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
